// File: rtl/i2c_reg_pkg.sv
// Shared definitions for the I2C register file: bit indices, widths,
// reset constants and the packed status layout.
package i2c_reg_pkg;

  // Status / interrupt-enable bit positions (same index in both registers)
  localparam int unsigned STOP_BIT      = 0;
  localparam int unsigned DIN_FULL_BIT  = 1;
  localparam int unsigned DIN_EMPTY_BIT = 2;
  localparam int unsigned DOUT_FULL_BIT = 3;
  localparam int unsigned ACK_BIT       = 4;
  localparam int unsigned NACK_BIT      = 5;
  localparam int unsigned BUS_BIT       = 6;
  localparam int unsigned ARB_BIT       = 7;

  // Remaining config bit positions
  localparam int unsigned FIFO_EN_BIT   = 8;
  localparam int unsigned PKT_TYPE_BIT  = 9;
  localparam int unsigned START_BIT     = 10;
  localparam int unsigned MACK_BIT      = 11;
  localparam int unsigned MNACK_BIT     = 12;
  localparam int unsigned SR_BIT        = 13;

  localparam int unsigned STATUS_W = 8;
  localparam int unsigned STICKY_W = 6;
  localparam int unsigned CFG_W    = 14;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned DIV_W    = 16;

  // Field order puts stop at bit 0 when viewed as a vector
  typedef struct packed {
    logic arb_loss;
    logic bus_available;
    logic slave_nack;
    logic slave_ack;
    logic dout_full;
    logic din_empty;
    logic din_full;
    logic stop;
  } status_t;

  localparam logic [CFG_W-1:0] CFG_RESET    = '0;
  localparam status_t          STATUS_RESET = status_t'(STATUS_W'(1) << BUS_BIT);

endpackage

// File: rtl/i2c_register_file_if.sv
// Core-side event/level bundle between the I2C core (master) and the
// register file (slave).
interface i2c_register_file_if;
  logic       core_rx_valid;
  logic [7:0] core_rx_data;
  logic       ev_stop;
  logic       ev_din_full;
  logic       ev_din_empty;
  logic       ev_dout_full;
  logic       ev_slave_ack;
  logic       ev_slave_nack;
  logic       bus_available_in;
  logic       arb_loss_in;
  logic       start_ack;
  logic       ackbit_done;
  logic       byte_read_pulse;
  logic       byte_written_pulse;

  modport master (
    output core_rx_valid, core_rx_data, ev_stop, ev_din_full, ev_din_empty,
           ev_dout_full, ev_slave_ack, ev_slave_nack, bus_available_in,
           arb_loss_in, start_ack, ackbit_done, byte_read_pulse, byte_written_pulse
  );

  modport slave (
    input  core_rx_valid, core_rx_data, ev_stop, ev_din_full, ev_din_empty,
           ev_dout_full, ev_slave_ack, ev_slave_nack, bus_available_in,
           arb_loss_in, start_ack, ackbit_done, byte_read_pulse, byte_written_pulse
  );
endinterface

// File: rtl/i2c_event_counter.sv
// Saturating up-counter with synchronous clear (clear has priority).
// Ports: clk, reset (async active-low), clr, inc, count.
module i2c_event_counter #(
  parameter int unsigned LEN_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [LEN_W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {LEN_W{1'b1}})) begin
      count <= count + LEN_W'(1);
    end
  end

endmodule

// File: rtl/i2c_register_file.sv
// Register storage for the I2C master: plain config/data registers,
// self-clearing command bits, sticky status, byte counters and irq.
// Ports: clk/reset, register-map we/_in/_out fields, status_we and
// status write values, core bundle (slave modport), byte counts, irq.
module i2c_register_file
  import i2c_reg_pkg::*;
#(
  parameter logic [15:0] CLK_DIV_RESET = 16'd250,
  parameter int unsigned LEN_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_out_we,
  input  logic [DATA_W-1:0] data_out_in,
  output logic [DATA_W-1:0] data_out_out,
  output logic [DATA_W-1:0] data_in_out,
  input  logic              read_length_we,
  input  logic [LEN_W-1:0]  read_length_in,
  output logic [LEN_W-1:0]  read_length_out,
  input  logic              write_length_we,
  input  logic [LEN_W-1:0]  write_length_in,
  output logic [LEN_W-1:0]  write_length_out,
  input  logic              clk_divider_we,
  input  logic [DIV_W-1:0]  clk_divider_in,
  output logic [DIV_W-1:0]  clk_divider_out,
  input  logic              config_we,
  input  logic              stop_ire_in, din_full_ire_in, din_empty_ire_in, dout_full_ire_in,
  input  logic              ack_ire_in, nack_ire_in, bus_ire_in, arb_ire_in,
  output logic              stop_ire_out, din_full_ire_out, din_empty_ire_out, dout_full_ire_out,
  output logic              ack_ire_out, nack_ire_out, bus_ire_out, arb_ire_out,
  input  logic              fifo_enable_in, packet_type_in, start_in,
  input  logic              master_ACK_in, master_NACK_in, sr_enable_in,
  output logic              fifo_enable_out, packet_type_out, start_out,
  output logic              master_ACK_out, master_NACK_out, sr_enable_out,
  input  logic              status_we,
  input  logic              stop_in, din_full_in, din_empty_in, dout_full_in,
  input  logic              slave_ACK_in, slave_NACK_in,
  output logic              stop_out, din_full_out, din_empty_out, dout_full_out,
  output logic              slave_ACK_out, slave_NACK_out, bus_available_out, arb_loss_out,
  i2c_register_file_if.slave core,
  output logic [LEN_W-1:0]  bytes_read_out,
  output logic [LEN_W-1:0]  bytes_written_out,
  output logic              irq
);

  logic [CFG_W-1:0]    cfg_q, cfg_wr, cfg_d;
  status_t             status_q, status_d;
  logic [STATUS_W-1:0] status_bits_q;
  logic [STICKY_W-1:0] ev_set, sw_wr, sw_clr, sw_set;
  logic                irq_d, cnt_clr;

  // Gather the 14 config write fields into one vector
  always_comb begin
    cfg_wr                = '0;
    cfg_wr[STOP_BIT]      = stop_ire_in;
    cfg_wr[DIN_FULL_BIT]  = din_full_ire_in;
    cfg_wr[DIN_EMPTY_BIT] = din_empty_ire_in;
    cfg_wr[DOUT_FULL_BIT] = dout_full_ire_in;
    cfg_wr[ACK_BIT]       = ack_ire_in;
    cfg_wr[NACK_BIT]      = nack_ire_in;
    cfg_wr[BUS_BIT]       = bus_ire_in;
    cfg_wr[ARB_BIT]       = arb_ire_in;
    cfg_wr[FIFO_EN_BIT]   = fifo_enable_in;
    cfg_wr[PKT_TYPE_BIT]  = packet_type_in;
    cfg_wr[START_BIT]     = start_in;
    cfg_wr[MACK_BIT]      = master_ACK_in;
    cfg_wr[MNACK_BIT]     = master_NACK_in;
    cfg_wr[SR_BIT]        = sr_enable_in;
  end

  // Config next state: a software write beats the core's self-clear
  always_comb begin
    cfg_d = cfg_q;
    if (config_we) begin
      cfg_d = cfg_wr;
    end else begin
      if (core.start_ack) cfg_d[START_BIT] = 1'b0;
      if (core.ackbit_done) begin
        cfg_d[MACK_BIT]  = 1'b0;
        cfg_d[MNACK_BIT] = 1'b0;
      end
    end
  end

  // Sticky status: hardware set beats software clear; only stop accepts a written 1
  always_comb begin
    status_bits_q = status_q;
    ev_set = {core.ev_slave_nack & ~cfg_q[FIFO_EN_BIT],
              core.ev_slave_ack  & ~cfg_q[FIFO_EN_BIT],
              core.ev_dout_full, core.ev_din_empty, core.ev_din_full, core.ev_stop};
    sw_wr  = {slave_NACK_in, slave_ACK_in, dout_full_in, din_empty_in, din_full_in, stop_in};
    sw_clr = {STICKY_W{status_we}} & ~sw_wr;
    sw_set = {{(STICKY_W-1){1'b0}}, status_we & stop_in};
    status_d = status_t'({core.arb_loss_in, core.bus_available_in,
                          ev_set | sw_set | (status_bits_q[STICKY_W-1:0] & ~sw_clr)});
    irq_d = |(status_bits_q & cfg_q[ARB_BIT:STOP_BIT]);
  end

  assign cnt_clr = config_we & start_in & ~cfg_q[START_BIT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_out     <= '0;
      data_in_out      <= '0;
      read_length_out  <= '0;
      write_length_out <= '0;
      clk_divider_out  <= CLK_DIV_RESET;
      cfg_q            <= CFG_RESET;
      status_q         <= STATUS_RESET;
      irq              <= 1'b0;
    end else begin
      if (data_out_we)        data_out_out     <= data_out_in;
      if (core.core_rx_valid) data_in_out      <= core.core_rx_data;
      if (read_length_we)     read_length_out  <= read_length_in;
      if (write_length_we)    write_length_out <= write_length_in;
      if (clk_divider_we)     clk_divider_out  <= clk_divider_in;
      cfg_q    <= cfg_d;
      status_q <= status_d;
      irq      <= irq_d;
    end
  end

  assign stop_ire_out      = cfg_q[STOP_BIT];
  assign din_full_ire_out  = cfg_q[DIN_FULL_BIT];
  assign din_empty_ire_out = cfg_q[DIN_EMPTY_BIT];
  assign dout_full_ire_out = cfg_q[DOUT_FULL_BIT];
  assign ack_ire_out       = cfg_q[ACK_BIT];
  assign nack_ire_out      = cfg_q[NACK_BIT];
  assign bus_ire_out       = cfg_q[BUS_BIT];
  assign arb_ire_out       = cfg_q[ARB_BIT];
  assign fifo_enable_out   = cfg_q[FIFO_EN_BIT];
  assign packet_type_out   = cfg_q[PKT_TYPE_BIT];
  assign start_out         = cfg_q[START_BIT];
  assign master_ACK_out    = cfg_q[MACK_BIT];
  assign master_NACK_out   = cfg_q[MNACK_BIT];
  assign sr_enable_out     = cfg_q[SR_BIT];

  assign stop_out          = status_q.stop;
  assign din_full_out      = status_q.din_full;
  assign din_empty_out     = status_q.din_empty;
  assign dout_full_out     = status_q.dout_full;
  assign slave_ACK_out     = status_q.slave_ack;
  assign slave_NACK_out    = status_q.slave_nack;
  assign bus_available_out = status_q.bus_available;
  assign arb_loss_out      = status_q.arb_loss;

  i2c_event_counter #(.LEN_W(LEN_W)) u_read_cnt (
    .clk(clk), .reset(reset), .clr(cnt_clr), .inc(core.byte_read_pulse), .count(bytes_read_out)
  );

  i2c_event_counter #(.LEN_W(LEN_W)) u_written_cnt (
    .clk(clk), .reset(reset), .clr(cnt_clr), .inc(core.byte_written_pulse), .count(bytes_written_out)
  );

endmodule

// File: tb/tb_i2c_register_file.sv
module tb_i2c_register_file;

  localparam int unsigned LW = 8;
  localparam int OP_DOUT = 0, OP_RX = 1, OP_RLEN = 2, OP_WLEN = 3, OP_DIV = 4, OP_CFG = 5;

  typedef struct {
    int          op;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          data_out_we, read_length_we, write_length_we, clk_divider_we, config_we, status_we;
  logic [7:0]    data_out_in;
  wire  [7:0]    data_out_out, data_in_out;
  logic [LW-1:0] read_length_in, write_length_in;
  wire  [LW-1:0] read_length_out, write_length_out, bytes_read_out, bytes_written_out;
  logic [15:0]   clk_divider_in;
  wire  [15:0]   clk_divider_out;
  logic [13:0]   cfg_in_v;
  wire  [13:0]   cfg_out_v;
  logic [5:0]    st_in_v;
  wire  [7:0]    st_out_v;
  logic [5:0]    ev_v;
  wire           irq;

  int n_cmp = 0;
  int n_fail = 0;
  vec_t vecs[11];

  i2c_register_file_if core_if ();

  assign core_if.ev_stop       = ev_v[0];
  assign core_if.ev_din_full   = ev_v[1];
  assign core_if.ev_din_empty  = ev_v[2];
  assign core_if.ev_dout_full  = ev_v[3];
  assign core_if.ev_slave_ack  = ev_v[4];
  assign core_if.ev_slave_nack = ev_v[5];

  i2c_register_file #(.CLK_DIV_RESET(16'd250), .LEN_W(LW)) dut (
    .clk(clk), .reset(reset),
    .data_out_we(data_out_we), .data_out_in(data_out_in), .data_out_out(data_out_out),
    .data_in_out(data_in_out),
    .read_length_we(read_length_we), .read_length_in(read_length_in), .read_length_out(read_length_out),
    .write_length_we(write_length_we), .write_length_in(write_length_in), .write_length_out(write_length_out),
    .clk_divider_we(clk_divider_we), .clk_divider_in(clk_divider_in), .clk_divider_out(clk_divider_out),
    .config_we(config_we),
    .stop_ire_in(cfg_in_v[0]), .din_full_ire_in(cfg_in_v[1]), .din_empty_ire_in(cfg_in_v[2]),
    .dout_full_ire_in(cfg_in_v[3]), .ack_ire_in(cfg_in_v[4]), .nack_ire_in(cfg_in_v[5]),
    .bus_ire_in(cfg_in_v[6]), .arb_ire_in(cfg_in_v[7]),
    .stop_ire_out(cfg_out_v[0]), .din_full_ire_out(cfg_out_v[1]), .din_empty_ire_out(cfg_out_v[2]),
    .dout_full_ire_out(cfg_out_v[3]), .ack_ire_out(cfg_out_v[4]), .nack_ire_out(cfg_out_v[5]),
    .bus_ire_out(cfg_out_v[6]), .arb_ire_out(cfg_out_v[7]),
    .fifo_enable_in(cfg_in_v[8]), .packet_type_in(cfg_in_v[9]), .start_in(cfg_in_v[10]),
    .master_ACK_in(cfg_in_v[11]), .master_NACK_in(cfg_in_v[12]), .sr_enable_in(cfg_in_v[13]),
    .fifo_enable_out(cfg_out_v[8]), .packet_type_out(cfg_out_v[9]), .start_out(cfg_out_v[10]),
    .master_ACK_out(cfg_out_v[11]), .master_NACK_out(cfg_out_v[12]), .sr_enable_out(cfg_out_v[13]),
    .status_we(status_we),
    .stop_in(st_in_v[0]), .din_full_in(st_in_v[1]), .din_empty_in(st_in_v[2]),
    .dout_full_in(st_in_v[3]), .slave_ACK_in(st_in_v[4]), .slave_NACK_in(st_in_v[5]),
    .stop_out(st_out_v[0]), .din_full_out(st_out_v[1]), .din_empty_out(st_out_v[2]),
    .dout_full_out(st_out_v[3]), .slave_ACK_out(st_out_v[4]), .slave_NACK_out(st_out_v[5]),
    .bus_available_out(st_out_v[6]), .arb_loss_out(st_out_v[7]),
    .core(core_if.slave),
    .bytes_read_out(bytes_read_out), .bytes_written_out(bytes_written_out),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One-cycle register-map write (or core rx strobe)
  task automatic apply(input int op, input logic [31:0] d);
    case (op)
      OP_DOUT: begin data_out_we = 1'b1; data_out_in = d[7:0]; end
      OP_RX:   begin core_if.core_rx_valid = 1'b1; core_if.core_rx_data = d[7:0]; end
      OP_RLEN: begin read_length_we = 1'b1; read_length_in = d[LW-1:0]; end
      OP_WLEN: begin write_length_we = 1'b1; write_length_in = d[LW-1:0]; end
      OP_DIV:  begin clk_divider_we = 1'b1; clk_divider_in = d[15:0]; end
      default: begin config_we = 1'b1; cfg_in_v = d[13:0]; end
    endcase
    step();
    data_out_we = 1'b0; core_if.core_rx_valid = 1'b0; read_length_we = 1'b0;
    write_length_we = 1'b0; clk_divider_we = 1'b0; config_we = 1'b0;
  endtask

  function automatic logic [31:0] read_out(input int op);
    case (op)
      OP_DOUT: return 32'(data_out_out);
      OP_RX:   return 32'(data_in_out);
      OP_RLEN: return 32'(read_length_out);
      OP_WLEN: return 32'(write_length_out);
      OP_DIV:  return 32'(clk_divider_out);
      default: return 32'(cfg_out_v);
    endcase
  endfunction

  task automatic pulse_ev(input int i);
    ev_v[i] = 1'b1;
    step();
    ev_v = '0;
  endtask

  task automatic status_write(input logic [5:0] v);
    status_we = 1'b1; st_in_v = v;
    step();
    status_we = 1'b0; st_in_v = '0;
  endtask

  task automatic pulse_rd(input int n);
    for (int k = 0; k < n; k++) begin
      core_if.byte_read_pulse = 1'b1;
      step();
      core_if.byte_read_pulse = 1'b0;
    end
  endtask

  initial begin
    vecs[0]  = '{OP_DOUT, 32'h0000_00A5, 32'h0000_00A5};
    vecs[1]  = '{OP_DOUT, 32'h0000_005A, 32'h0000_005A};
    vecs[2]  = '{OP_RX,   32'h0000_003C, 32'h0000_003C};
    vecs[3]  = '{OP_RX,   32'h0000_00C3, 32'h0000_00C3};
    vecs[4]  = '{OP_RLEN, 32'h0000_0080, 32'h0000_0080};
    vecs[5]  = '{OP_WLEN, 32'h0000_007F, 32'h0000_007F};
    vecs[6]  = '{OP_DIV,  32'h0000_1234, 32'h0000_1234};
    vecs[7]  = '{OP_DIV,  32'h0000_FFFF, 32'h0000_FFFF};
    vecs[8]  = '{OP_CFG,  32'h0000_2AAA, 32'h0000_2AAA};
    vecs[9]  = '{OP_CFG,  32'h0000_1555, 32'h0000_1555};
    vecs[10] = '{OP_CFG,  32'h0000_0000, 32'h0000_0000};

    reset = 1'b0;
    data_out_we = 1'b0; read_length_we = 1'b0; write_length_we = 1'b0;
    clk_divider_we = 1'b0; config_we = 1'b0; status_we = 1'b0;
    data_out_in = '0; read_length_in = '0; write_length_in = '0; clk_divider_in = '0;
    cfg_in_v = '0; st_in_v = '0; ev_v = '0;
    core_if.core_rx_valid = 1'b0; core_if.core_rx_data = '0;
    core_if.bus_available_in = 1'b1; core_if.arb_loss_in = 1'b0;
    core_if.start_ack = 1'b0; core_if.ackbit_done = 1'b0;
    core_if.byte_read_pulse = 1'b0; core_if.byte_written_pulse = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();

    // Reset state
    check("rst_div", 32'(clk_divider_out), 32'd250);
    check("rst_status", 32'(st_out_v), 32'h40);
    check("rst_cfg", 32'(cfg_out_v), 32'h0);
    check("rst_dout", 32'(data_out_out), 32'h0);
    check("rst_counts", {16'(bytes_read_out), 16'(bytes_written_out)}, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);

    // Plain register table
    for (int i = 0; i < 11; i++) begin
      apply(vecs[i].op, vecs[i].data);
      check($sformatf("vec%0d", i), read_out(vecs[i].op), vecs[i].exp);
    end
    step();

    // bus_available participates in irq
    apply(OP_CFG, 32'h0040);
    check("bus_irq_n1", 32'(irq), 32'h0);
    step();
    check("bus_irq_n2", 32'(irq), 32'h1);
    apply(OP_CFG, 32'h0000);
    step();
    check("bus_irq_off", 32'(irq), 32'h0);

    // slave NACK event, irq latency, software clear
    apply(OP_CFG, 32'h0020);
    pulse_ev(5);
    check("nack_set", 32'(st_out_v[5]), 32'h1);
    check("nack_irq_n1", 32'(irq), 32'h0);
    step();
    check("nack_irq_n2", 32'(irq), 32'h1);
    status_write(6'h00);
    check("nack_clr", 32'(st_out_v[5]), 32'h0);
    check("nack_clr_irq_n1", 32'(irq), 32'h1);
    step();
    check("nack_clr_irq_n2", 32'(irq), 32'h0);
    apply(OP_CFG, 32'h0120);
    ev_v[4] = 1'b1; ev_v[5] = 1'b1;
    step();
    ev_v = '0;
    check("fifo_gate", 32'(st_out_v[5:4]), 32'h0);
    apply(OP_CFG, 32'h0000);

    // Other sticky bits: set, written 1 ignored, written 0 clears
    for (int i = 1; i < 4; i++) begin
      pulse_ev(i);
      check($sformatf("ev%0d_set", i), 32'(st_out_v), 32'h40 | (32'h1 << i));
      status_write(6'h3E);
      check($sformatf("ev%0d_w1", i), 32'(st_out_v), 32'h40 | (32'h1 << i));
      status_write(6'h3E & ~(6'h1 << i));
      check($sformatf("ev%0d_clr", i), 32'(st_out_v), 32'h40);
    end

    // STOP: hardware set beats software clear; written 1 sets
    ev_v[0] = 1'b1; status_we = 1'b1; st_in_v = 6'h00;
    step();
    ev_v = '0; status_we = 1'b0;
    check("stop_hw_wins", 32'(st_out_v[0]), 32'h1);
    status_write(6'h00);
    check("stop_sw_clr", 32'(st_out_v[0]), 32'h0);
    status_write(6'h01);
    check("stop_sw_set", 32'(st_out_v[0]), 32'h1);
    status_write(6'h00);

    // arb_loss follows core level, status_we has no effect
    core_if.arb_loss_in = 1'b1; status_we = 1'b1; st_in_v = 6'h00;
    step();
    status_we = 1'b0;
    check("arb_copy", 32'(st_out_v[7:6]), 32'h3);
    core_if.arb_loss_in = 1'b0;
    step();
    check("arb_drop", 32'(st_out_v[7]), 32'h0);

    // Counters, then START write and self-clear
    core_if.byte_written_pulse = 1'b1;
    pulse_rd(2);
    core_if.byte_written_pulse = 1'b0;
    pulse_rd(1);
    check("cnt_rd", 32'(bytes_read_out), 32'd3);
    check("cnt_wr", 32'(bytes_written_out), 32'd2);
    apply(OP_CFG, 32'h0400);
    check("start_cnt_clr", {16'(bytes_read_out), 16'(bytes_written_out)}, 32'h0);
    check("start_hi0", 32'(cfg_out_v[10]), 32'h1);
    for (int k = 1; k < 5; k++) begin
      step();
      check($sformatf("start_hi%0d", k), 32'(cfg_out_v[10]), 32'h1);
    end
    core_if.start_ack = 1'b1;
    step();
    core_if.start_ack = 1'b0;
    check("start_ack_clr", 32'(cfg_out_v[10]), 32'h0);

    // Write beats same-cycle start_ack; non-rising write keeps counts
    core_if.start_ack = 1'b1;
    apply(OP_CFG, 32'h0400);
    core_if.start_ack = 1'b0;
    check("start_write_wins", 32'(cfg_out_v[10]), 32'h1);
    pulse_rd(1);
    apply(OP_CFG, 32'h0400);
    check("start_no_rise", 32'(bytes_read_out), 32'd1);
    core_if.start_ack = 1'b1;
    step();
    core_if.start_ack = 1'b0;

    // master ACK / NACK self-clear and write priority
    apply(OP_CFG, 32'h0800);
    check("mack_set", 32'(cfg_out_v[12:11]), 32'h1);
    core_if.ackbit_done = 1'b1;
    step();
    check("mack_clr", 32'(cfg_out_v[12:11]), 32'h0);
    apply(OP_CFG, 32'h1000);
    check("mnack_write_wins", 32'(cfg_out_v[12:11]), 32'h2);
    step();
    core_if.ackbit_done = 1'b0;
    check("mnack_clr", 32'(cfg_out_v[12:11]), 32'h0);

    // Saturation
    apply(OP_CFG, 32'h0400);
    apply(OP_CFG, 32'h0000);
    pulse_rd(254);
    check("sat_fe", 32'(bytes_read_out), 32'hFE);
    pulse_rd(1);
    check("sat_ff", 32'(bytes_read_out), 32'hFF);
    pulse_rd(2);
    check("sat_hold", 32'(bytes_read_out), 32'hFF);
    core_if.byte_read_pulse = 1'b1;
    apply(OP_CFG, 32'h0400);
    core_if.byte_read_pulse = 1'b0;
    check("clr_beats_inc", 32'(bytes_read_out), 32'h0);

    // Asynchronous reset mid-count with irq high
    apply(OP_CFG, 32'h0001);
    pulse_ev(0);
    pulse_rd(2);
    apply(OP_DIV, 32'h0777);
    apply(OP_DOUT, 32'h11);
    check("pre_rst_irq", 32'(irq), 32'h1);
    check("pre_rst_cnt", 32'(bytes_read_out), 32'd2);
    #1 reset = 1'b0;
    #1;
    check("arst_irq", 32'(irq), 32'h0);
    check("arst_div", 32'(clk_divider_out), 32'd250);
    check("arst_cnt", 32'(bytes_read_out), 32'h0);
    check("arst_status", 32'(st_out_v), 32'h40);
    check("arst_cfg", 32'(cfg_out_v), 32'h0);
    check("arst_dout", 32'(data_out_out), 32'h0);
    step();
    reset = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
